fetch_issue_controller: RTL
===========================

Name: fetch_issue_controller

Overview:
Multi-cycle sequencer for the instruction-fetch datapath (Program_Counter -> Instruction_Memory -> Get_Instruction). It drives the PC enable and the memory read enable, and latches each fetched word into an instruction register. It presents each word to the execute stage through a valid/ready handshake. Sequencing stops on a halt opcode or at the last PC address.

Parameters:
PC_WIDTH, 4, width of the program counter / memory address
LAST_ADDR, 15, final instruction address; after issuing it, the controller halts instead of advancing the PC
HALT_OPCODE, 6'h3F, opcode (instruction[31:26]) treated as halt; never issued

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; returns the block to IDLE
start  input  1  begin sequencing; sampled only in IDLE
pc  input  PC_WIDTH  current PC from Program_Counter
instruction  input  32  combinational read data from Instruction_Memory
exec_ready  input  1  downstream accepts the issued instruction
mem_read_en  output  1  read enable to Instruction_Memory
pc_enable  output  1  one-cycle advance pulse to Program_Counter
ir  output  32  latched instruction register, feeds Get_Instruction
ir_valid  output  1  ir holds an instruction being offered downstream
halted  output  1  sequencing finished
state  output  2  FSM state: 0 IDLE, 1 FETCH, 2 ISSUE, 3 HALT
instr_count  output  8  number of instructions accepted downstream

Behaviour:
- Reset (synchronous, highest priority, including mid-operation): state=IDLE, ir=0, instr_count=0. All 1-bit outputs are 0. The controller does not reset the PC; the PC has its own reset.
- Outputs mem_read_en, ir_valid and halted are Moore outputs: mem_read_en = (state==FETCH), ir_valid = (state==ISSUE), halted = (state==HALT).
- pc_enable = (state==ISSUE) & exec_ready & (pc != LAST_ADDR). This output is combinational and is never asserted outside ISSUE.
- IDLE: if start=1, go to FETCH next cycle. Otherwise stay in IDLE.
- FETCH (exactly one cycle):
  - ir <= instruction at the edge leaving FETCH.
  - If instruction[31:26]==HALT_OPCODE, go to HALT. ir still captures the word; no issue occurs and instr_count is unchanged.
  - Otherwise go to ISSUE.
- ISSUE: ir is held stable while exec_ready=0, with no PC change and no count change. On a cycle with exec_ready=1 the handshake completes:
  - instr_count increments, saturating at 255.
  - If pc==LAST_ADDR, go to HALT with no pc_enable pulse (the PC never wraps).
  - Otherwise pc_enable=1 that cycle and the next state is FETCH.
- HALT: absorbing state; only reset exits it. start is ignored.
- start outside IDLE is ignored. start and reset in the same cycle: reset wins.
- Latency and throughput:
  - start sampled at edge k gives FETCH during cycle k+1.
  - ir_valid=1 from cycle k+2.
  - With exec_ready tied high: one instruction per 2 cycles, with pc_enable on every ISSUE cycle.
- Memory read is combinational. The address is stable during FETCH because the PC only moves on the pc_enable edge in ISSUE.
- ir changes only at a FETCH exit edge or at reset.

Test Plan:
1. Assert reset for 2 cycles, then release. Required: state=0, ir=0, ir_valid=0, mem_read_en=0, pc_enable=0, halted=0, instr_count=0.
2. Memory words 0..3 = 012A4020, 8D090004, 01095022, AD0A0008, word 4 = FC000000; exec_ready=1; pulse start.
   - Required: ir presents the four words in order, each with ir_valid for 1 cycle.
   - Required: 4 pc_enable pulses, 2 cycles apart.
   - Required: then state=3, halted=1, ir=FC000000, instr_count=4.
3. Hold exec_ready=0 for 3 cycles during the first ISSUE. Required: ir_valid=1 and ir=012A4020 stay stable; pc_enable=0; pc stays 0; instr_count stays 0. On release, count=1 and pc becomes 1.
4. All 16 words non-halt; exec_ready=1. Required: 16 issues, 15 pc_enable pulses, final pc=15 (no wrap to 0), halted=1, instr_count=16.
5. Assert reset during ISSUE at instruction 2. Required: next cycle state=0, ir=0, ir_valid=0, instr_count=0. A fresh start then fetches from the current pc value.
6. Pulse start during ISSUE and during HALT. Required: no state change. Assert start together with reset in IDLE. Required: state remains 0.

Source files
------------

// File: rtl/fetch_issue_controller_if.sv
// Bus between the fetch/issue sequencer and its surroundings: PC, instruction
// memory and the execute-stage handshake. The controller side uses "master".
interface fetch_issue_controller_if #(
   parameter int PC_WIDTH = 4
);
   logic                start;
   logic [PC_WIDTH-1:0] pc;
   logic [31:0]         instruction;
   logic                exec_ready;
   logic                mem_read_en;
   logic                pc_enable;
   logic [31:0]         ir;
   logic                ir_valid;
   logic                halted;
   logic [1:0]          state;
   logic [7:0]          instr_count;

   modport master (
      input  start, pc, instruction, exec_ready,
      output mem_read_en, pc_enable, ir, ir_valid, halted, state, instr_count
   );

   modport slave (
      output start, pc, instruction, exec_ready,
      input  mem_read_en, pc_enable, ir, ir_valid, halted, state, instr_count
   );
endinterface

// File: rtl/fetch_issue_controller.sv
// Sequencer for PC -> instruction memory -> instruction register: fetches one
// word per FETCH cycle and offers it downstream via a valid/ready handshake.
module fetch_issue_controller #(
   parameter int          PC_WIDTH    = 4,
   parameter int unsigned LAST_ADDR   = 15,
   parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
   input logic                      clock,
   input logic                      reset,
   fetch_issue_controller_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      HALT  = 2'd3
   } state_e;

   localparam logic [PC_WIDTH-1:0] LastPc = LAST_ADDR[PC_WIDTH-1:0];

   state_e      state_q, state_d;
   logic [31:0] ir_q, ir_d;
   logic [7:0]  count_q, count_d;
   logic        pcEnable;
   logic        handshake;
   logic        atLast;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ir_q    <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         count_q <= count_d;
      end
   end

   assign handshake = (state_q == ISSUE) && bus.exec_ready;
   assign atLast    = (bus.pc == LastPc);

   // The PC only moves on a completed handshake, so the memory address is
   // stable for the whole FETCH cycle; at the last address we halt instead.
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      count_d  = count_q;
      pcEnable = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            ir_d = bus.instruction;
            if (bus.instruction[31:26] == HALT_OPCODE) begin
               state_d = HALT;
            end else begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (handshake) begin
               count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
               if (atLast) begin
                  state_d = HALT;
               end else begin
                  pcEnable = 1'b1;
                  state_d  = FETCH;
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.mem_read_en = (state_q == FETCH);
   assign bus.ir_valid    = (state_q == ISSUE);
   assign bus.halted      = (state_q == HALT);
   assign bus.pc_enable   = pcEnable;
   assign bus.ir          = ir_q;
   assign bus.state       = state_q;
   assign bus.instr_count = count_q;

endmodule
